mcbsp_master_tx: RTL and testbench

- Parametrised McBSP master transmitter that drives gated bit clock, frame sync and serial data towards the DSP receive port.
- Replaces the fixed 8-bit / fixed-latency transmitter. Adds generic word width, runtime frame length and data delay, and a request/valid word handshake with a one-word prefetch buffer.
- Adds clock stall on data underrun, plus programmable lead/tail clocks so the clock starts before the first sync and stops cleanly after the last bit.

---
 rtl/mcbsp_master_tx.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_mcbsp_master_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mcbsp_master_tx.sv
// mcbsp_master_tx: McBSP master transmitter.
// Drives a gated bit clock, frame sync and MSB-first serial data towards a
// DSP receive port. Words come from a request/valid source through a
// one-word prefetch buffer. The clock stalls while the buffer is empty, and
// programmable lead/tail clocks frame the burst.
// Optional build macro: MCBSP_PARITY_EN appends an even-parity bit after
// the LSB of every word.
// All registers update on the falling edge of mcbsp_clk_in, so data and
// frame sync are stable around the DSP's rising-edge sampling point.

module mcbsp_master_tx #(
    parameter int WORD_W       = 8,
    parameter int NUM_W        = 9,
    parameter int LEAD_CLKS    = 4,
    parameter int TAIL_CLKS    = 2,
    parameter int FSR_ACT_HIGH = 1
) (
    input  logic              mcbsp_clk_in,
    input  logic              mcbsp_rst_n_in,
    input  logic [NUM_W-1:0]  cfg_word_num,
    input  logic [1:0]        cfg_data_dly,
    input  logic              frame_start,
    output logic              word_req,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              mcbsp_master_clkr,
    output logic              mcbsp_master_fsr,
    output logic              mcbsp_master_miso,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SLOT,
        STALL,
        TAIL
    } state_t;

    localparam logic [5:0] WORD_LEN  = 6'(WORD_W);
`ifdef MCBSP_PARITY_EN
    localparam logic [5:0] PAR_LEN   = 6'd1;
`else
    localparam logic [5:0] PAR_LEN   = 6'd0;
`endif
    localparam logic [5:0] LEAD_LAST = 6'(LEAD_CLKS - 1);
    localparam logic [5:0] TAIL_LAST = (TAIL_CLKS > 0) ? 6'(TAIL_CLKS - 1) : 6'd0;
    localparam logic       FSR_ON    = (FSR_ACT_HIGH != 0);

    state_t              state_q, state_nxt;
    logic [5:0]          cnt_q, cnt_nxt;
    logic [NUM_W-1:0]    wcnt_q, wcnt_nxt;
    logic [NUM_W-1:0]    num_q, num_nxt;
    logic [1:0]          dly_q, dly_nxt;
    logic [WORD_W-1:0]   shift_q, shift_nxt;
    logic [WORD_W-1:0]   buf_q, buf_nxt;
    logic                buf_full_q, buf_full_nxt;
    logic                pend_q, pend_nxt;
    logic                req_q, req_nxt;
    logic                clk_en_q, clk_en_nxt;
    logic                fsr_on_q, fsr_on_nxt;
    logic                miso_q, miso_nxt;
    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;
    logic                underrun_q, underrun_nxt;
`ifdef MCBSP_PARITY_EN
    logic                parity_q, parity_nxt;
`endif

    logic                accept;
    logic                load;
    logic [NUM_W-1:0]    load_idx;
    logic [5:0]          dly6;
    logic [5:0]          slot_last;
    logic [5:0]          c_next;

    assign dly6      = {4'd0, dly_q};
    assign slot_last = dly6 + WORD_LEN + PAR_LEN - 6'd1;
    assign c_next    = cnt_q + 6'd1;
    assign accept    = word_valid & pend_q & ~req_q;

    // Next-state, handshake and serial output logic
    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt_q;
        wcnt_nxt     = wcnt_q;
        num_nxt      = num_q;
        dly_nxt      = dly_q;
        shift_nxt    = shift_q;
        buf_nxt      = buf_q;
        buf_full_nxt = buf_full_q;
        pend_nxt     = pend_q;
        req_nxt      = 1'b0;
        clk_en_nxt   = clk_en_q;
        fsr_on_nxt   = 1'b0;
        miso_nxt     = miso_q;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;
        underrun_nxt = 1'b0;
`ifdef MCBSP_PARITY_EN
        parity_nxt   = parity_q;
`endif
        load         = 1'b0;
        load_idx     = wcnt_q;

        if (accept) begin
            buf_nxt      = word_data;
            buf_full_nxt = 1'b1;
            pend_nxt     = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (frame_start && !busy_q) begin
                    num_nxt    = cfg_word_num;
                    dly_nxt    = (cfg_data_dly == 2'd3) ? 2'd2 : cfg_data_dly;
                    busy_nxt   = 1'b1;
                    clk_en_nxt = 1'b1;
                    req_nxt    = 1'b1;
                    pend_nxt   = 1'b1;
                    wcnt_nxt   = '0;
                    cnt_nxt    = '0;
                    miso_nxt   = 1'b0;
                    state_nxt  = LEAD;
                end
            end

            LEAD: begin
                miso_nxt = 1'b0;
                if (cnt_q == LEAD_LAST) begin
                    if (buf_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_nxt    = STALL;
                        clk_en_nxt   = 1'b0;
                        underrun_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = c_next;
                end
            end

            SLOT: begin
                if (cnt_q == slot_last) begin
                    if (wcnt_q == num_q) begin
                        if (TAIL_CLKS == 0) begin
                            state_nxt  = IDLE;
                            clk_en_nxt = 1'b0;
                            busy_nxt   = 1'b0;
                            done_nxt   = 1'b1;
                            wcnt_nxt   = '0;
                            miso_nxt   = 1'b0;
                        end else begin
                            state_nxt = TAIL;
                            cnt_nxt   = '0;
                            miso_nxt  = 1'b0;
                        end
                    end else begin
                        wcnt_nxt = wcnt_q + NUM_W'(1);
                        if (buf_full_q) begin
                            load     = 1'b1;
                            load_idx = wcnt_q + NUM_W'(1);
                        end else begin
                            state_nxt    = STALL;
                            clk_en_nxt   = 1'b0;
                            underrun_nxt = 1'b1;
                        end
                    end
                end else begin
                    cnt_nxt = c_next;
                    if (c_next < dly6) begin
                        miso_nxt = 1'b0;
                    end else if (c_next < dly6 + WORD_LEN) begin
                        miso_nxt  = shift_q[WORD_W-1];
                        shift_nxt = {shift_q[WORD_W-2:0], 1'b0};
                    end else begin
`ifdef MCBSP_PARITY_EN
                        miso_nxt = parity_q;
`else
                        miso_nxt = 1'b0;
`endif
                    end
                end
            end

            STALL: begin
                if (buf_full_q) begin
                    load = 1'b1;
                end
            end

            TAIL: begin
                miso_nxt = 1'b0;
                if (cnt_q == TAIL_LAST) begin
                    state_nxt  = IDLE;
                    clk_en_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                    done_nxt   = 1'b1;
                    wcnt_nxt   = '0;
                end else begin
                    cnt_nxt = c_next;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Slot entry: the first slot cycle already carries the MSB when the
        // data delay is zero, so the shift register is pre-advanced here.
        if (load) begin
            state_nxt    = SLOT;
            cnt_nxt      = '0;
            clk_en_nxt   = 1'b1;
            fsr_on_nxt   = 1'b1;
            buf_full_nxt = 1'b0;
`ifdef MCBSP_PARITY_EN
            parity_nxt   = ^buf_q;
`endif
            if (dly_q == 2'd0) begin
                miso_nxt  = buf_q[WORD_W-1];
                shift_nxt = {buf_q[WORD_W-2:0], 1'b0};
            end else begin
                miso_nxt  = 1'b0;
                shift_nxt = buf_q;
            end
            if (load_idx != num_q) begin
                req_nxt  = 1'b1;
                pend_nxt = 1'b1;
            end
        end
    end

    // State and output registers, falling-edge clocked with async reset
    always_ff @(negedge mcbsp_clk_in or negedge mcbsp_rst_n_in) begin
        if (!mcbsp_rst_n_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            num_q      <= '0;
            dly_q      <= '0;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            pend_q     <= 1'b0;
            req_q      <= 1'b0;
            clk_en_q   <= 1'b0;
            fsr_on_q   <= 1'b0;
            miso_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
`ifdef MCBSP_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            wcnt_q     <= wcnt_nxt;
            num_q      <= num_nxt;
            dly_q      <= dly_nxt;
            shift_q    <= shift_nxt;
            buf_q      <= buf_nxt;
            buf_full_q <= buf_full_nxt;
            pend_q     <= pend_nxt;
            req_q      <= req_nxt;
            clk_en_q   <= clk_en_nxt;
            fsr_on_q   <= fsr_on_nxt;
            miso_q     <= miso_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            underrun_q <= underrun_nxt;
`ifdef MCBSP_PARITY_EN
            parity_q   <= parity_nxt;
`endif
        end
    end

    // clk_en only changes while mcbsp_clk_in is low, so the AND gate
    // passes whole high phases and never produces a runt pulse.
    assign mcbsp_master_clkr = mcbsp_clk_in & clk_en_q;
    assign mcbsp_master_fsr  = fsr_on_q ? FSR_ON : ~FSR_ON;
    assign mcbsp_master_miso = miso_q;
    assign word_req          = req_q;
    assign busy              = busy_q;
    assign frame_done        = done_q;
    assign underrun          = underrun_q;

endmodule

// File: tb/tb_mcbsp_master_tx.sv
// tb_mcbsp_master_tx: randomized self-checking bench for mcbsp_master_tx.
// A word source answers requests after a per-word delay. The bench predicts
// the serial stream seen on clkr rising edges and the frame timing from the
// frame rules, then compares both against what the DUT produces.
`timescale 1ns/1ps

module tb_mcbsp_master_tx;

    localparam int WORD_W = 8;
    localparam int NUM_W  = 9;
    localparam int LEAD   = 4;
    localparam int TAIL   = 2;
    localparam int ACT    = 1;
`ifdef MCBSP_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_W-1:0]  cfg_word_num = '0;
    logic [1:0]        cfg_data_dly = '0;
    logic              frame_start = 1'b0;
    logic              word_req;
    logic [WORD_W-1:0] word_data = '0;
    logic              word_valid = 1'b0;
    logic              clkr, fsr, miso, busy, frame_done, underrun;

    mcbsp_master_tx #(
        .WORD_W(WORD_W), .NUM_W(NUM_W), .LEAD_CLKS(LEAD),
        .TAIL_CLKS(TAIL), .FSR_ACT_HIGH(ACT)
    ) dut (
        .mcbsp_clk_in(clk), .mcbsp_rst_n_in(rst_n),
        .cfg_word_num(cfg_word_num), .cfg_data_dly(cfg_data_dly),
        .frame_start(frame_start), .word_req(word_req),
        .word_data(word_data), .word_valid(word_valid),
        .mcbsp_master_clkr(clkr), .mcbsp_master_fsr(fsr),
        .mcbsp_master_miso(miso), .busy(busy),
        .frame_done(frame_done), .underrun(underrun)
    );

    always #25 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [WORD_W-1:0] words[64];
    int                dlys[64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One frame: n = words-1, dly = cfg value, inject = stray start/valid,
    // abort_at >= 0 asserts reset in that cycle instead of finishing.
    task automatic run_frame(input int n, input int dly, input bit inject, input int abort_at);
        int eff, s, sp, done_exp, stalls, t, reqs, unr, done_t, widx, due, limit;
        bit pending, busy_at_done;
        logic [1:0] exp_q[$];
        logic [1:0] got_q[$];
        logic [WORD_W-1:0] w;
        eff = (dly == 3) ? 2 : dly;
        s   = WORD_W + eff + PAR;
        for (int i = 0; i < LEAD; i++) exp_q.push_back(2'b00);
        for (int i = 0; i <= n; i++) begin
            w = words[i];
            for (int c = 0; c < s; c++) begin
                logic b;
                if (c < eff) b = 1'b0;
                else if (c < eff + WORD_W) b = w[WORD_W-1-(c-eff)];
                else b = ^w;
                exp_q.push_back({(c == 0), b});
            end
        end
        for (int i = 0; i < TAIL; i++) exp_q.push_back(2'b00);
        sp = (dlys[0] + 2 > LEAD) ? dlys[0] + 2 : LEAD;
        stalls = (dlys[0] + 2 > LEAD) ? 1 : 0;
        for (int i = 1; i <= n; i++) begin
            if (dlys[i] + 2 > s) begin
                stalls++;
                sp = sp + dlys[i] + 2;
            end else begin
                sp = sp + s;
            end
        end
        done_exp = sp + s + TAIL;
        limit = done_exp + 50;

        @(posedge clk); #1;
        cfg_word_num = NUM_W'(n);
        cfg_data_dly = 2'(dly);
        frame_start = 1'b1;
        reqs = 0; unr = 0; done_t = -1; widx = 0; due = 0; pending = 0;
        busy_at_done = 1'b1;
        for (t = 0; t < limit; t++) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
            word_valid = 1'b0;
            if (t == 0) check("busy_after_start", 32'(busy), 32'd1);
            if (clkr) got_q.push_back({fsr == (ACT != 0), miso});
            if (underrun) unr++;
            if (frame_done) begin
                done_t = t;
                busy_at_done = busy;
                break;
            end
            if (word_req) begin
                reqs++;
                pending = 1'b1;
                due = t + dlys[widx];
            end
            if (pending && t == due) begin
                word_valid = 1'b1;
                word_data = words[widx];
                widx++;
                pending = 1'b0;
            end else if (inject && !pending && $urandom_range(0, 3) == 0) begin
                word_valid = 1'b1;
                word_data = WORD_W'($urandom);
            end
            if (inject && busy && $urandom_range(0, 7) == 0) frame_start = 1'b1;
            if (abort_at >= 0 && t == abort_at) begin
                #4;
                rst_n = 1'b0;
                frame_start = 1'b0;
                word_valid = 1'b0;
                #1;
                check("rst_clkr", 32'(clkr), 32'd0);
                check("rst_fsr", 32'(fsr), (ACT != 0) ? 32'd0 : 32'd1);
                check("rst_miso", 32'(miso), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                repeat (2) @(posedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        frame_start = 1'b0;
        word_valid = 1'b0;
        check("done_cycle", 32'(done_t), 32'(done_exp));
        check("busy_at_done", 32'(busy_at_done), 32'd0);
        check("underruns", 32'(unr), 32'(stalls));
        check("word_reqs", 32'(reqs), 32'(n + 1));
        check("clkr_pulses", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("fsr_miso[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_clkr0", 32'(clkr), 32'd0);
        check("rst_fsr0", 32'(fsr), (ACT != 0) ? 32'd0 : 32'd1);
        check("rst_miso0", 32'(miso), 32'd0);
        check("rst_busy0", 32'(busy), 32'd0);
        check("rst_req0", 32'(word_req), 32'd0);
        check("rst_done0", 32'(frame_done), 32'd0);
        check("rst_unr0", 32'(underrun), 32'd0);
        @(posedge clk);
        rst_n = 1'b1;

        // single word 0xA5, delay 1, source answers 2 cycles after request
        words[0] = 8'hA5; dlys[0] = 2;
        run_frame(0, 1, 1'b0, -1);

        // four back-to-back words, no delay
        words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF; words[3] = 8'h3C;
        for (int i = 0; i < 4; i++) dlys[i] = 1;
        run_frame(3, 0, 1'b0, -1);

        // second word 20 cycles late
        for (int i = 0; i < 3; i++) words[i] = WORD_W'($urandom);
        dlys[0] = 1; dlys[1] = 20; dlys[2] = 1;
        run_frame(2, 2, 1'b0, -1);

        // stray frame_start and word_valid, delay code 3
        for (int i = 0; i < 5; i++) begin
            words[i] = WORD_W'($urandom);
            dlys[i] = $urandom_range(1, 3);
        end
        run_frame(4, 3, 1'b1, -1);

        // reset mid-slot, then a fresh frame
        for (int i = 0; i < 4; i++) begin
            words[i] = WORD_W'($urandom);
            dlys[i] = 1;
        end
        run_frame(3, 1, 1'b0, 10);
        for (int i = 0; i < 2; i++) begin
            words[i] = WORD_W'($urandom);
            dlys[i] = 1;
        end
        run_frame(1, 1, 1'b0, -1);

        // parity-relevant single words
        words[0] = 8'h07; dlys[0] = 1;
        run_frame(0, 0, 1'b0, -1);
        words[0] = 8'h03; dlys[0] = 1;
        run_frame(0, 0, 1'b0, -1);

        // random frames
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(0, 5);
            for (int i = 0; i <= n; i++) begin
                words[i] = WORD_W'($urandom);
                dlys[i] = $urandom_range(1, 12);
            end
            run_frame(n, $urandom_range(0, 3), f[0], -1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
